// File: rtl/traffic_sel_gen.sv
// traffic_sel_gen: per-frame vehicle pixel density, windowed average and hysteresis light/heavy mode offer
// Optional build macro TRAFFIC_SEL_OVERRIDE_EN adds sw_force/sw_val to force the committed mode.
module traffic_sel_gen #(
   parameter int CNT_W    = 17,
   parameter int AVG_LOG2 = 2,
   parameter int HIGH_TH  = 12000,
   parameter int LOW_TH   = 8000,
   parameter int HOLD_SEC = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             frame_start,
   input  logic             pix_valid,
   input  logic             pix_vehicle,
   input  logic             tick_sec,
   input  logic             tr_valid,
   output logic             traffic_sel,
   output logic             sel_valid,
   output logic [CNT_W-1:0] frame_density,
   output logic [CNT_W-1:0] avg_density,
   output logic             avg_update
`ifdef TRAFFIC_SEL_OVERRIDE_EN
   ,
   input  logic             sw_force,
   input  logic             sw_val
`endif
);
   localparam int SUM_W  = CNT_W + AVG_LOG2;
   localparam int HOLD_W = $clog2(HOLD_SEC + 1);
   localparam logic [CNT_W-1:0] HI_TH = CNT_W'(HIGH_TH);
   localparam logic [CNT_W-1:0] LO_TH = CNT_W'(LOW_TH);
   // bit 1 is the committed mode, bit 1 ^ bit 0 marks a pending offer
   typedef enum logic [1:0] {
      LIGHT      = 2'b00,
      PEND_HEAVY = 2'b01,
      HEAVY      = 2'b11,
      PEND_LIGHT = 2'b10
   } state_t;
   state_t               r_state, w_state_nxt;
   logic [CNT_W-1:0]     r_pix_cnt;
   logic [SUM_W-1:0]     r_sum;
   logic [AVG_LOG2-1:0]  r_idx;
   logic [HOLD_W-1:0]    r_hold;
   logic [SUM_W-1:0]     w_sum_nxt;
   logic                 w_hit, w_commit, w_force, w_force_val;
   assign w_hit     = pix_valid & pix_vehicle;
   assign w_sum_nxt = r_sum + SUM_W'(r_pix_cnt);
`ifdef TRAFFIC_SEL_OVERRIDE_EN
   assign w_force     = sw_force;
   assign w_force_val = sw_val;
`else
   assign w_force     = 1'b0;
   assign w_force_val = 1'b0;
`endif
   // saturating pixel counter; a vehicle pixel on frame_start belongs to the new frame
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pix_cnt     <= '0;
         frame_density <= '0;
      end else if (frame_start) begin
         frame_density <= r_pix_cnt;
         r_pix_cnt     <= CNT_W'(w_hit);
      end else if (w_hit && r_pix_cnt != '1) begin
         r_pix_cnt <= r_pix_cnt + 1'b1;
      end
   end
   // window accumulator; the last frame of the window publishes the average and clears
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sum       <= '0;
         r_idx       <= '0;
         avg_density <= '0;
         avg_update  <= 1'b0;
      end else begin
         avg_update <= 1'b0;
         if (frame_start && r_idx == '1) begin
            avg_density <= CNT_W'(w_sum_nxt >> AVG_LOG2);
            avg_update  <= 1'b1;
            r_sum       <= '0;
            r_idx       <= '0;
         end else if (frame_start) begin
            r_sum <= w_sum_nxt;
            r_idx <= r_idx + 1'b1;
         end
      end
   end
   // classifier state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= LIGHT;
      else        r_state <= w_state_nxt;
   end
   // hysteresis next state and handshake outputs; a commit beats a same-cycle cancel
   always_comb begin
      w_state_nxt = r_state;
      traffic_sel = r_state[1];
      sel_valid   = (r_state[1] ^ r_state[0]) & ~w_force;
      w_commit    = sel_valid & tr_valid;
      case (r_state)
         LIGHT:      if (avg_update && avg_density >= HI_TH && r_hold == '0) w_state_nxt = PEND_HEAVY;
         PEND_HEAVY: if (tr_valid) w_state_nxt = HEAVY;
                     else if (avg_update && avg_density < LO_TH) w_state_nxt = LIGHT;
         HEAVY:      if (avg_update && avg_density < LO_TH && r_hold == '0) w_state_nxt = PEND_LIGHT;
         PEND_LIGHT: if (tr_valid) w_state_nxt = LIGHT;
                     else if (avg_update && avg_density >= HI_TH) w_state_nxt = HEAVY;
      endcase
      if (w_force) w_state_nxt = w_force_val ? HEAVY : LIGHT;
   end
   // minimum hold between commits; a commit load beats a same-cycle tick
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                       r_hold <= '0;
      else if (w_force)                 r_hold <= '0;
      else if (w_commit)                r_hold <= HOLD_W'(HOLD_SEC);
      else if (tick_sec && r_hold != '0) r_hold <= r_hold - 1'b1;
   end
endmodule
